// File: rtl/noc_pkg.sv
// Shared 2D-mesh NoC constants: flit ID encoding, router port indices and
// head-flit field layout, common to the packetizer and depacketizer.
package noc_pkg;

   localparam int FLIT_ID_W = 2;

   localparam logic [FLIT_ID_W-1:0] ID_NULL = 2'b00;
   localparam logic [FLIT_ID_W-1:0] ID_HEAD = 2'b01;
   localparam logic [FLIT_ID_W-1:0] ID_BODY = 2'b10;
   localparam logic [FLIT_ID_W-1:0] ID_TAIL = 2'b11;

   localparam int PORT_TERM  = 0;
   localparam int PORT_LEFT  = 1;
   localparam int PORT_UP    = 2;
   localparam int PORT_RIGHT = 3;
   localparam int PORT_DOWN  = 4;

   // Head flit data is {zero pad, dst_row, dst_col}; the column sits in the LSBs.
   localparam int HEAD_COL_LSB = 0;

   function automatic int head_row_lsb(input int col_addr_w);
      return HEAD_COL_LSB + col_addr_w;
   endfunction

endpackage

// File: rtl/mesh_packetizer.sv
// Turns one message per handshake into a wormhole packet (HEAD, BODY..., TAIL)
// for the terminal input port of a 2D-mesh XY NoC node.
module mesh_packetizer #(
   parameter int ROW_N       = 3,
   parameter int COL_M       = 3,
   parameter int CHANNEL_W   = 8,
   parameter int FLIT_ID_W   = noc_pkg::FLIT_ID_W,
   parameter int PLD_FLITS_N = 3,
   localparam int FLIT_DATA_W = CHANNEL_W - FLIT_ID_W,
   localparam int ROW_ADDR_W  = $clog2(ROW_N),
   localparam int COL_ADDR_W  = $clog2(COL_M)
) (
   input  logic                               clk_i,
   input  logic                               rst_i,
   input  logic [PLD_FLITS_N*FLIT_DATA_W-1:0] msg_data_i,
   input  logic [ROW_ADDR_W-1:0]              msg_dst_row_i,
   input  logic [COL_ADDR_W-1:0]              msg_dst_col_i,
   input  logic                               msg_vld_i,
   output logic                               msg_rdy_o,
   output logic [CHANNEL_W-1:0]               flit_data_o,
   output logic                               flit_vld_o,
   input  logic                               flit_rdy_i,
   output logic                               dst_err_o
);
   import noc_pkg::*;

   localparam int CNT_W = (PLD_FLITS_N > 1) ? $clog2(PLD_FLITS_N) : 1;
   localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(PLD_FLITS_N - 1);
   localparam int ROW_LSB = head_row_lsb(COL_ADDR_W);

   if (ROW_ADDR_W + COL_ADDR_W > FLIT_DATA_W) begin : g_err_head
      $error("mesh_packetizer: destination does not fit in head flit data");
   end
   if (PLD_FLITS_N < 1) begin : g_err_pld
      $error("mesh_packetizer: PLD_FLITS_N must be at least 1");
   end
   if (FLIT_ID_W != noc_pkg::FLIT_ID_W) begin : g_err_id
      $error("mesh_packetizer: FLIT_ID_W must match the NoC package");
   end

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_HEAD = 2'd1,
      ST_PLD  = 2'd2
   } state_e;

   state_e                             state_r;
   logic [PLD_FLITS_N*FLIT_DATA_W-1:0] pld_r;
   logic [CNT_W-1:0]                   cnt_r;

   logic                   dst_ok_s;
   logic [FLIT_DATA_W-1:0] head_s;
   logic [CNT_W-1:0]       sel_cnt_s;
   logic [FLIT_ID_W-1:0]   sel_id_s;
   logic [FLIT_DATA_W-1:0] sel_chunk_s;

   // Destination check, head flit data and the payload flit shown after the next acceptance.
   always_comb begin
      dst_ok_s = (32'(msg_dst_row_i) < 32'(ROW_N)) && (32'(msg_dst_col_i) < 32'(COL_M));
      head_s = '0;
      head_s[HEAD_COL_LSB +: COL_ADDR_W] = msg_dst_col_i;
      head_s[ROW_LSB +: ROW_ADDR_W] = msg_dst_row_i;
      // Clamped so the chunk select never leaves the payload vector.
      if (state_r != ST_PLD || cnt_r == LAST_CNT) begin
         sel_cnt_s = '0;
      end else begin
         sel_cnt_s = cnt_r + CNT_W'(1);
      end
      if (sel_cnt_s == LAST_CNT) begin
         sel_id_s = ID_TAIL;
      end else begin
         sel_id_s = ID_BODY;
      end
      sel_chunk_s = pld_r[sel_cnt_s*FLIT_DATA_W +: FLIT_DATA_W];
   end

   // Packet FSM with registered handshake, flit and error outputs.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_r     <= ST_IDLE;
         pld_r       <= '0;
         cnt_r       <= '0;
         msg_rdy_o   <= 1'b1;
         flit_vld_o  <= 1'b0;
         flit_data_o <= '0;
         dst_err_o   <= 1'b0;
      end else begin
         dst_err_o <= 1'b0;
         case (state_r)
            ST_IDLE: begin
               if (msg_vld_i) begin
                  if (dst_ok_s) begin
                     pld_r       <= msg_data_i;
                     cnt_r       <= '0;
                     state_r     <= ST_HEAD;
                     msg_rdy_o   <= 1'b0;
                     flit_vld_o  <= 1'b1;
                     flit_data_o <= {ID_HEAD, head_s};
                  end else begin
                     dst_err_o <= 1'b1;
                  end
               end
            end
            ST_HEAD: begin
               if (flit_rdy_i) begin
                  state_r     <= ST_PLD;
                  flit_data_o <= {sel_id_s, sel_chunk_s};
               end
            end
            ST_PLD: begin
               if (flit_rdy_i) begin
                  if (cnt_r == LAST_CNT) begin
                     state_r     <= ST_IDLE;
                     cnt_r       <= '0;
                     msg_rdy_o   <= 1'b1;
                     flit_vld_o  <= 1'b0;
                     flit_data_o <= '0;
                  end else begin
                     cnt_r       <= sel_cnt_s;
                     flit_data_o <= {sel_id_s, sel_chunk_s};
                  end
               end
            end
            default: begin
               state_r     <= ST_IDLE;
               cnt_r       <= '0;
               msg_rdy_o   <= 1'b1;
               flit_vld_o  <= 1'b0;
               flit_data_o <= '0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_mesh_packetizer.sv
// Directed bench for mesh_packetizer: vector table of single packets plus
// hand-written backpressure, reset, back-to-back and single-payload sequences.
module tb_mesh_packetizer;

   logic clk;
   logic rst;

   logic [17:0] a_data;
   logic [1:0]  a_row;
   logic [1:0]  a_col;
   logic        a_vld;
   logic        a_msg_rdy;
   logic [7:0]  a_flit_data;
   logic        a_flit_vld;
   logic        a_frdy;
   logic        a_dst_err;

   logic [5:0]  b_data;
   logic [1:0]  b_row;
   logic [1:0]  b_col;
   logic        b_vld;
   logic        b_msg_rdy;
   logic [7:0]  b_flit_data;
   logic        b_flit_vld;
   logic        b_frdy;
   logic        b_dst_err;

   int total;
   int bad;

   mesh_packetizer #(.ROW_N(3), .COL_M(3), .CHANNEL_W(8), .PLD_FLITS_N(3)) dut_a (
      .clk_i(clk), .rst_i(rst),
      .msg_data_i(a_data), .msg_dst_row_i(a_row), .msg_dst_col_i(a_col),
      .msg_vld_i(a_vld), .msg_rdy_o(a_msg_rdy),
      .flit_data_o(a_flit_data), .flit_vld_o(a_flit_vld), .flit_rdy_i(a_frdy),
      .dst_err_o(a_dst_err)
   );

   mesh_packetizer #(.ROW_N(3), .COL_M(3), .CHANNEL_W(8), .PLD_FLITS_N(1)) dut_b (
      .clk_i(clk), .rst_i(rst),
      .msg_data_i(b_data), .msg_dst_row_i(b_row), .msg_dst_col_i(b_col),
      .msg_vld_i(b_vld), .msg_rdy_o(b_msg_rdy),
      .flit_data_o(b_flit_data), .flit_vld_o(b_flit_vld), .flit_rdy_i(b_frdy),
      .dst_err_o(b_dst_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [1:0]  row;
      logic [1:0]  col;
      logic [17:0] data;
      logic        err;
      logic [7:0]  f [4];
   } vec_t;

   vec_t vecs [6];

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h want %0h at %0t", nm, act, exp, $time);
      end
   endtask

   // Presents one message on port A for a single cycle; returns at the negedge after acceptance.
   task automatic send_a(input logic [1:0] row, input logic [1:0] col, input logic [17:0] data);
      a_row  = row;
      a_col  = col;
      a_data = data;
      a_vld  = 1'b1;
      @(negedge clk);
      a_vld  = 1'b0;
   endtask

   // Expects four consecutive flits with flit_rdy held high, then an idle port.
   task automatic expect_pkt(input string tag, input logic [7:0] e0, input logic [7:0] e1,
                             input logic [7:0] e2, input logic [7:0] e3);
      logic [7:0] e [4];
      e[0] = e0; e[1] = e1; e[2] = e2; e[3] = e3;
      for (int k = 0; k < 4; k++) begin
         chk({tag, "_vld"}, 32'(a_flit_vld), 32'd1);
         chk({tag, "_flit"}, 32'(a_flit_data), 32'(e[k]));
         chk({tag, "_busy"}, 32'(a_msg_rdy), 32'd0);
         @(negedge clk);
      end
      chk({tag, "_end_vld"}, 32'(a_flit_vld), 32'd0);
      chk({tag, "_end_rdy"}, 32'(a_msg_rdy), 32'd1);
   endtask

   logic       b2b_vld [10];
   logic [7:0] b2b_dat [10];

   initial begin
      total = 0;
      bad   = 0;
      rst = 1'b1;
      a_data = '0; a_row = '0; a_col = '0; a_vld = 1'b0; a_frdy = 1'b0;
      b_data = '0; b_row = '0; b_col = '0; b_vld = 1'b0; b_frdy = 1'b0;

      vecs[0] = '{2'd2, 2'd1, 18'h3F56A, 1'b0, '{8'h49, 8'hAA, 8'h95, 8'hFF}};
      vecs[1] = '{2'd0, 2'd0, 18'h01FC0, 1'b0, '{8'h40, 8'h80, 8'hBF, 8'hC1}};
      vecs[2] = '{2'd3, 2'd0, 18'h3F56A, 1'b1, '{8'h00, 8'h00, 8'h00, 8'h00}};
      vecs[3] = '{2'd1, 2'd2, 18'h33891, 1'b0, '{8'h46, 8'h91, 8'hA2, 8'hF3}};
      vecs[4] = '{2'd0, 2'd3, 18'h00000, 1'b1, '{8'h00, 8'h00, 8'h00, 8'h00}};
      vecs[5] = '{2'd2, 2'd2, 18'h00000, 1'b0, '{8'h4A, 8'h80, 8'h80, 8'hC0}};

      repeat (2) @(negedge clk);
      chk("rst_msg_rdy", 32'(a_msg_rdy), 32'd1);
      chk("rst_flit_vld", 32'(a_flit_vld), 32'd0);
      chk("rst_flit_data", 32'(a_flit_data), 32'd0);
      chk("rst_dst_err", 32'(a_dst_err), 32'd0);
      chk("rst_b_vld", 32'(b_flit_vld), 32'd0);
      rst = 1'b0;
      @(negedge clk);

      // Table of single messages, flit_rdy held high.
      a_frdy = 1'b1;
      for (int i = 0; i < 6; i++) begin
         chk("vec_idle_rdy", 32'(a_msg_rdy), 32'd1);
         send_a(vecs[i].row, vecs[i].col, vecs[i].data);
         if (vecs[i].err) begin
            chk("vec_err_pulse", 32'(a_dst_err), 32'd1);
            chk("vec_err_novld", 32'(a_flit_vld), 32'd0);
            chk("vec_err_rdy", 32'(a_msg_rdy), 32'd1);
            @(negedge clk);
            chk("vec_err_once", 32'(a_dst_err), 32'd0);
            chk("vec_err_novld2", 32'(a_flit_vld), 32'd0);
         end else begin
            expect_pkt("vec", vecs[i].f[0], vecs[i].f[1], vecs[i].f[2], vecs[i].f[3]);
         end
      end

      // Back-to-back illegal messages: one pulse each, msg_rdy stays high.
      a_row = 2'd3; a_col = 2'd1; a_vld = 1'b1;
      @(negedge clk);
      chk("ill2_pulse1", 32'(a_dst_err), 32'd1);
      chk("ill2_rdy1", 32'(a_msg_rdy), 32'd1);
      @(negedge clk);
      a_vld = 1'b0;
      chk("ill2_pulse2", 32'(a_dst_err), 32'd1);
      chk("ill2_rdy2", 32'(a_msg_rdy), 32'd1);
      chk("ill2_novld", 32'(a_flit_vld), 32'd0);
      @(negedge clk);
      chk("ill2_clear", 32'(a_dst_err), 32'd0);

      // Backpressure: every flit stalled three cycles before acceptance.
      a_frdy = 1'b0;
      send_a(2'd2, 2'd1, 18'h3F56A);
      for (int k = 0; k < 4; k++) begin
         logic [7:0] ef;
         ef = vecs[0].f[k];
         repeat (3) begin
            chk("bp_hold_vld", 32'(a_flit_vld), 32'd1);
            chk("bp_hold_flit", 32'(a_flit_data), 32'(ef));
            @(negedge clk);
         end
         chk("bp_acc_flit", 32'(a_flit_data), 32'(ef));
         a_frdy = 1'b1;
         @(negedge clk);
         a_frdy = 1'b0;
      end
      chk("bp_end_vld", 32'(a_flit_vld), 32'd0);
      chk("bp_end_rdy", 32'(a_msg_rdy), 32'd1);

      // Reset while the 0x95 flit is stalled, then a fresh packet.
      a_frdy = 1'b1;
      send_a(2'd2, 2'd1, 18'h3F56A);
      @(negedge clk);
      @(negedge clk);
      a_frdy = 1'b0;
      chk("rstm_pre_flit", 32'(a_flit_data), 32'h95);
      @(negedge clk);
      chk("rstm_stall_flit", 32'(a_flit_data), 32'h95);
      #2 rst = 1'b1;
      #1;
      chk("rstm_vld", 32'(a_flit_vld), 32'd0);
      chk("rstm_rdy", 32'(a_msg_rdy), 32'd1);
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      chk("rstm_idle_vld", 32'(a_flit_vld), 32'd0);
      a_frdy = 1'b1;
      send_a(2'd2, 2'd1, 18'h3F56A);
      expect_pkt("rstm_next", 8'h49, 8'hAA, 8'h95, 8'hFF);

      // Back-to-back messages with msg_vld held: second HEAD five cycles after the first.
      b2b_vld = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
      b2b_dat = '{8'h49, 8'hAA, 8'h95, 8'hFF, 8'h00, 8'h49, 8'hAA, 8'h95, 8'hFF, 8'h00};
      a_row = 2'd2; a_col = 2'd1; a_data = 18'h3F56A; a_vld = 1'b1;
      for (int c = 0; c < 10; c++) begin
         @(negedge clk);
         if (c == 5) a_vld = 1'b0;
         chk("b2b_vld", 32'(a_flit_vld), 32'(b2b_vld[c]));
         if (b2b_vld[c]) begin
            chk("b2b_flit", 32'(a_flit_data), 32'(b2b_dat[c]));
         end else begin
            chk("b2b_gap_rdy", 32'(a_msg_rdy), 32'd1);
         end
      end

      // Single payload flit: HEAD then TAIL.
      b_frdy = 1'b1;
      b_row = 2'd0; b_col = 2'd2; b_data = 6'h07; b_vld = 1'b1;
      @(negedge clk);
      b_vld = 1'b0;
      chk("p1_head_vld", 32'(b_flit_vld), 32'd1);
      chk("p1_head", 32'(b_flit_data), 32'h42);
      chk("p1_busy", 32'(b_msg_rdy), 32'd0);
      @(negedge clk);
      chk("p1_tail_vld", 32'(b_flit_vld), 32'd1);
      chk("p1_tail", 32'(b_flit_data), 32'hC7);
      @(negedge clk);
      chk("p1_end_vld", 32'(b_flit_vld), 32'd0);
      chk("p1_end_rdy", 32'(b_msg_rdy), 32'd1);
      chk("p1_no_err", 32'(b_dst_err), 32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/mesh_packetizer.md
# mesh_packetizer

Converts one message per handshake into a wormhole packet for a single terminal input port of the 2D-mesh XY NoC. The packet is one HEAD flit carrying the XY destination, then payload flits, with the last payload flit tagged TAIL. It sits between a resource (core or DMA) and that node's terminal slice of the NoC flit input (data/vld/rdy). It honours wormhole rules: flits of one packet are contiguous, and each flit is held stable until accepted.

## Interface
Parameters:
- ROW_N, 3, mesh rows (>= 2)
- COL_M, 3, mesh columns (>= 2)
- CHANNEL_W, 8, flit width including ID
- FLIT_ID_W, 2, flit ID width (constant)
- PLD_FLITS_N, 3, payload flits per packet (>= 1); packet length = PLD_FLITS_N + 1
- Derived: FLIT_DATA_W = CHANNEL_W - FLIT_ID_W; ROW_ADDR_W = $clog2(ROW_N); COL_ADDR_W = $clog2(COL_M)

Ports:
- Clock and reset: one clock; reset is asynchronous and active-high.
- clk_i  in  1  clock
- rst_i  in  1  asynchronous reset, active-high
- msg_data_i  in  PLD_FLITS_N*FLIT_DATA_W  payload; chunk k = bits [(k+1)*FLIT_DATA_W-1 : k*FLIT_DATA_W]
- msg_dst_row_i  in  ROW_ADDR_W  destination row
- msg_dst_col_i  in  COL_ADDR_W  destination column
- msg_vld_i  in  1  message valid
- msg_rdy_o  out  1  packetizer can accept a message
- flit_data_o  out  CHANNEL_W  flit to NoC terminal input
- flit_vld_o  out  1  flit valid
- flit_rdy_i  in  1  NoC terminal input ready
- dst_err_o  out  1  one-cycle pulse: message dropped, destination out of range

## Operation
- Flit format: flit = {id[FLIT_ID_W-1:0], data[FLIT_DATA_W-1:0]}, with the ID in the MSBs.
- ID encoding: NULL = 2'b00, HEAD = 2'b01, BODY = 2'b10, TAIL = 2'b11.
- HEAD data: {zero pad, dst_row, dst_col}, with the column in the LSBs.
- FSM has three states: IDLE, HEAD, PLD.
- IDLE:
  - msg_rdy_o = 1 and flit_vld_o = 0.
  - On msg_vld_i, the message is captured (payload, row, column), the chunk counter is cleared, and the next state is HEAD.
  - If msg_dst_row_i >= ROW_N or msg_dst_col_i >= COL_M, the message is accepted but not captured: dst_err_o pulses the next cycle and the FSM stays in IDLE.
- HEAD:
  - flit_vld_o = 1 and flit_data_o = the HEAD flit.
  - On flit_rdy_i, the next state is PLD.
- PLD:
  - flit_vld_o = 1 and flit_data_o = {id, chunk[cnt]}.
  - id = TAIL when cnt == PLD_FLITS_N-1, otherwise BODY.
  - On flit_rdy_i: if cnt is the last chunk, go to IDLE; otherwise cnt increments.
  - With PLD_FLITS_N = 1 the packet is HEAD then TAIL.
- The chunk counter is $clog2(PLD_FLITS_N)-bit (minimum 1 bit) and never wraps past PLD_FLITS_N-1.
- msg_rdy_o is 0 in HEAD and PLD. No message can interleave a packet in flight.
- Elaboration error if ROW_ADDR_W + COL_ADDR_W > FLIT_DATA_W, or if PLD_FLITS_N < 1.

## Timing
- All outputs are registered.
- Reset values: FSM = IDLE, msg_rdy_o = 1, flit_vld_o = 0, flit_data_o = 0, dst_err_o = 0, counter = 0.
- Asserting rst_i mid-packet immediately drops flit_vld_o. The partial packet is discarded; no TAIL is emitted.
- Latency: message accepted at edge T gives the HEAD flit valid at cycle T+1.
- With flit_rdy_i held at 1, the TAIL is accepted at edge T+1+PLD_FLITS_N and msg_rdy_o returns to 1 in the following cycle.
- Steady-state cost with flit_rdy_i = 1 is PLD_FLITS_N + 2 cycles per packet.
- Flit handshake: a transfer occurs when flit_vld_o && flit_rdy_i at the rising edge.
- While flit_vld_o = 1 and flit_rdy_i = 0, flit_data_o and flit_vld_o hold. flit_vld_o never drops before acceptance.
- flit_rdy_i arriving in the same cycle as a new message in IDLE is ignored (no flit is valid).
- dst_err_o is high for exactly one cycle per dropped message.
- Back-to-back illegal messages yield one pulse each, with msg_rdy_o staying at 1.

## Structure
- Shared package noc_pkg holds:
  - FLIT_ID_W;
  - the ID constants HEAD, BODY, TAIL, NULL;
  - the port indices TERM = 0, LEFT = 1, UP = 2, RIGHT = 3, DOWN = 4;
  - the head-flit field layout (row/column offsets).
- The block is a single module with no sub-module.
- A matching depacketizer will reuse the same package constants.

## Test plan
Common configuration: ROW_N = COL_M = 3, CHANNEL_W = 8, PLD_FLITS_N = 3, with chunks 0x2A, 0x15, 0x3F, so msg_data_i = 18'h3F56A.
- Basic packet: row 2, column 1, flit_rdy_i = 1 → flits 0x49, 0xAA, 0x95, 0xFF on consecutive cycles starting T+1; msg_rdy_o low for 4 cycles.
- Backpressure: same message with flit_rdy_i = 0 for 3 cycles during each flit → every flit held stable; the same 4-flit sequence with no duplicates.
- Illegal destination: row 3 (≥ ROW_N) → dst_err_o pulses once, no flit_vld_o, msg_rdy_o stays 1; a legal message right after produces a correct packet.
- PLD_FLITS_N = 1, row 0, column 2, chunk 0x07 → flits 0x42 then 0xC7.
- Reset mid-packet: rst_i asserted while the 0x95 flit is stalled → flit_vld_o = 0 and msg_rdy_o = 1 immediately; the next message starts with a HEAD flit.
- Back-to-back messages with msg_vld_i held at 1 and flit_rdy_i = 1 → the second HEAD appears exactly 5 cycles after the first; no gap inside either packet.
